// File: rtl/constraint_merge_checker.sv
// Merges per-split constraint results into sweep statistics (SAT count, first SAT index, fail mask).
// Optional CMC_EARLY_STOP_EN: the first fully satisfied beat ends the sweep.
module constraint_merge_checker #(
    parameter int unsigned NUM_SPLITS = 8,
    parameter int unsigned IDX_W      = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic [NUM_SPLITS-1:0] in_split,
    input  logic                  in_last,
    output logic                  done,
    output logic                  sat_found,
    output logic [IDX_W-1:0]      first_sat_idx,
    output logic [CNT_W-1:0]      sat_count,
    output logic [NUM_SPLITS-1:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_s1_valid;
    logic                  r_s1_sat;
    logic [IDX_W-1:0]      r_s1_idx;
    logic [NUM_SPLITS-1:0] r_s1_fail;

    logic                  r_sat_found;
    logic [IDX_W-1:0]      r_first_sat_idx;
    logic [CNT_W-1:0]      r_sat_count;
    logic [NUM_SPLITS-1:0] r_fail_mask;

    logic                  w_accept;
    logic                  w_beat_sat;
    logic                  w_beat_last;
    logic                  w_clear;

    assign w_accept   = in_valid && (r_state == S_RUN);
    assign w_beat_sat = &in_split;
    assign w_clear    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef CMC_EARLY_STOP_EN
    assign w_beat_last = in_last || w_beat_sat;
`else
    assign w_beat_last = in_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && w_beat_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_s1_valid <= 1'b0;
            r_s1_sat   <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_fail  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sat  <= w_beat_sat;
                r_s1_idx  <= in_idx;
                r_s1_fail <= ~in_split;
            end
        end
    end

    // S1 is only valid in RUN/DRAIN, so a clear (IDLE/DONE only) never races an update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_found     <= 1'b0;
            r_first_sat_idx <= '0;
            r_sat_count     <= '0;
            r_fail_mask     <= '0;
        end else if (w_clear) begin
            r_sat_found     <= 1'b0;
            r_first_sat_idx <= '0;
            r_sat_count     <= '0;
            r_fail_mask     <= '0;
        end else if (r_s1_valid) begin
            r_fail_mask <= r_fail_mask | r_s1_fail;
            if (r_s1_sat) begin
                if (r_sat_count != '1) begin
                    r_sat_count <= r_sat_count + CNT_W'(1);
                end
                if (!r_sat_found) begin
                    r_sat_found     <= 1'b1;
                    r_first_sat_idx <= r_s1_idx;
                end
            end
        end
    end

    assign in_ready      = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign sat_found     = r_sat_found;
    assign first_sat_idx = r_first_sat_idx;
    assign sat_count     = r_sat_count;
    assign fail_mask     = r_fail_mask;

endmodule

// File: tb/tb_constraint_merge_checker.sv
// Scoreboard bench for constraint_merge_checker: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_constraint_merge_checker;

    localparam bit ES = `ifdef CMC_EARLY_STOP_EN 1'b1 `else 1'b0 `endif ;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_idx = '0;
    logic [7:0]  in_split = '0;
    logic        in_last = 1'b0;

    logic        in_ready, done, sat_found;
    logic [15:0] first_sat_idx, sat_count;
    logic [7:0]  fail_mask;

    logic        in_ready2, done2, sat_found2;
    logic [15:0] first_sat_idx2;
    logic [1:0]  sat_count2;
    logic [7:0]  fail_mask2;

    always #5 clk = ~clk;

    constraint_merge_checker #(.NUM_SPLITS(8), .IDX_W(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_split(in_split), .in_last(in_last), .done(done),
        .sat_found(sat_found), .first_sat_idx(first_sat_idx), .sat_count(sat_count),
        .fail_mask(fail_mask)
    );

    constraint_merge_checker #(.NUM_SPLITS(8), .IDX_W(16), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .in_idx(in_idx), .in_split(in_split), .in_last(in_last), .done(done2),
        .sat_found(sat_found2), .first_sat_idx(first_sat_idx2), .sat_count(sat_count2),
        .fail_mask(fail_mask2)
    );

    typedef struct {
        logic [15:0] idx;
        logic [7:0]  sp;
        logic        lst;
    } beat_t;

    typedef struct {
        logic        found;
        logic [15:0] first;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [7:0]  mask;
    } exp_t;

    beat_t bq[$];
    exp_t  sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, {31'b0, in_ready}, 0);
        check({tag, "_done"}, {31'b0, done}, 0);
        check({tag, "_found"}, {31'b0, sat_found}, 0);
        check({tag, "_first"}, {16'b0, first_sat_idx}, 0);
        check({tag, "_cnt"}, {16'b0, sat_count}, 0);
        check({tag, "_mask"}, {24'b0, fail_mask}, 0);
        check({tag, "_cnt2"}, {30'b0, sat_count2}, 0);
    endtask

    task automatic push_beat(input logic [15:0] idx, input logic [7:0] sp, input logic lst);
        beat_t b;
        b.idx = idx;
        b.sp  = sp;
        b.lst = lst;
        bq.push_back(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one beat, wait (bounded) for in_ready, and on the sweep's final beat check done latency.
    task automatic send_beat(input logic [15:0] idx, input logic [7:0] sp, input logic lst,
                             input logic eff_last);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_idx   = idx;
        in_split = sp;
        in_last  = lst;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", {31'b0, in_ready}, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (eff_last) begin
            check("done_lat_t", {31'b0, done}, 0);
            check("ready_drain", {31'b0, in_ready}, 0);
            @(posedge clk); #1;
            check("done_lat_t1", {31'b0, done}, 1);
            check("done_sat_inst", {31'b0, done2}, 1);
        end
    endtask

    task automatic compare_results(input string tag, input exp_t e);
        check({tag, "_found"}, {31'b0, sat_found}, {31'b0, e.found});
        check({tag, "_first"}, {16'b0, first_sat_idx}, {16'b0, e.first});
        check({tag, "_cnt"}, {16'b0, sat_count}, {16'b0, e.cnt});
        check({tag, "_mask"}, {24'b0, fail_mask}, {24'b0, e.mask});
        check({tag, "_cnt2"}, {30'b0, sat_count2}, {30'b0, e.cnt2});
        check({tag, "_mask2"}, {24'b0, fail_mask2}, {24'b0, e.mask});
    endtask

    task automatic run_sweep(input string tag, input int unsigned gap_max, input bit mid_start);
        exp_t        e;
        int unsigned n_eff;
        int unsigned g;
        bit          stop;
        e.found = 1'b0; e.first = '0; e.cnt = '0; e.cnt2 = '0; e.mask = '0;
        n_eff = 0;
        stop  = 1'b0;
        foreach (bq[i]) begin
            if (!stop) begin
                n_eff++;
                e.mask |= ~bq[i].sp;
                if (&bq[i].sp) begin
                    if (!e.found) begin
                        e.found = 1'b1;
                        e.first = bq[i].idx;
                    end
                    if (e.cnt != 16'hFFFF) e.cnt++;
                    if (e.cnt2 != 2'd3) e.cnt2++;
                    if (ES) stop = 1'b1;
                end
                if (bq[i].lst) stop = 1'b1;
            end
        end
        sb_q.push_back(e);

        pulse_start();
        check({tag, "_ready_run"}, {31'b0, in_ready}, 1);
        check({tag, "_cleared"}, {16'b0, sat_count}, 0);
        for (int i = 0; i < int'(n_eff); i++) begin
            if (gap_max > 0) begin
                g = $urandom_range(gap_max, 1);
                if (mid_start && i == 1) begin
                    pulse_start();
                    check({tag, "_start_ignored"}, {31'b0, in_ready}, 1);
                    g--;
                end
                repeat (g) @(posedge clk);
                #1;
            end
            send_beat(bq[i].idx, bq[i].sp, bq[i].lst, i == int'(n_eff) - 1);
        end

        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            compare_results(tag, e);
            // Beats offered while DONE must be ignored.
            in_valid = 1'b1; in_split = 8'h00; in_idx = 16'hDEAD; in_last = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            in_valid = 1'b0; in_last = 1'b0;
            check({tag, "_done_hold"}, {31'b0, done}, 1);
            compare_results({tag, "_hold"}, e);
        end
        bq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with arbitrary inputs active.
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_split = 8'hFF; in_idx = 16'h1234; in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        start = 1'b0; in_last = 1'b0;
        rst_n = 1'b1;
        // Valid in IDLE: ignored.
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_zero("idle_valid");

        // Mixed SAT/UNSAT sweep.
        push_beat(16'd3, 8'hFF, 1'b0);
        push_beat(16'd4, 8'hFE, 1'b0);
        push_beat(16'd7, 8'hFF, 1'b0);
        push_beat(16'd9, 8'h7F, 1'b1);
        run_sweep("mixed", 0, 1'b0);

        // No SAT at all.
        push_beat(16'd1, 8'hBF, 1'b0);
        push_beat(16'd2, 8'hBF, 1'b0);
        push_beat(16'd3, 8'hBF, 1'b1);
        run_sweep("nosat", 0, 1'b0);

        // Same beats as the mixed sweep, with gaps and a start pulse mid-RUN.
        push_beat(16'd3, 8'hFF, 1'b0);
        push_beat(16'd4, 8'hFE, 1'b0);
        push_beat(16'd7, 8'hFF, 1'b0);
        push_beat(16'd9, 8'h7F, 1'b1);
        run_sweep("gaps", 3, 1'b1);

        // UNSAT beats before the first SAT one; earliest, not smallest, index wins.
        push_beat(16'd40, 8'h0F, 1'b0);
        push_beat(16'd30, 8'hFF, 1'b0);
        push_beat(16'd10, 8'hFF, 1'b0);
        push_beat(16'd20, 8'hF7, 1'b1);
        run_sweep("order", 2, 1'b0);

        // Single-beat sweep.
        push_beat(16'd77, 8'hFF, 1'b1);
        run_sweep("single", 0, 1'b0);

        // Five SAT beats: the CNT_W=2 instance saturates at 3.
        for (int i = 0; i < 5; i++) push_beat(16'(100 + i), 8'hFF, i == 4);
        run_sweep("satur", 0, 1'b0);

        // Reset mid-sweep discards partial results.
        pulse_start();
        send_beat(16'd1, 8'hFF, 1'b0, ES);
        if (!ES) send_beat(16'd2, 8'hFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("midrst_partial_cnt", {16'b0, sat_count}, ES ? 32'd1 : 32'd2);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_beat(16'd5, 8'hFF, 1'b1);
        run_sweep("after_rst", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
